// File: rtl/reg_file_mp_scoreboard.sv
// Multi-ported register file with an integrated busy/tag status table.
// Optional macro RF_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file_mp_scoreboard #(
  parameter int unsigned      ADDR     = 5,
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NRD      = 4,
  parameter int unsigned      NWR      = 2,
  parameter int unsigned      NAL      = 2,
  parameter int unsigned      TAG      = 6,
  parameter int unsigned      SP_IDX   = 2,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(32'h7fffeffc)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*ADDR-1:0]  rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAG-1:0]   rd_tag,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*ADDR-1:0]  wr_addr,
  input  logic [NWR*TAG-1:0]   wr_tag,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NAL-1:0]       al_en,
  input  logic [NAL*ADDR-1:0]  al_addr,
  input  logic [NAL*TAG-1:0]   al_tag,
  input  logic                 flush
);

  localparam int unsigned NREG = 2 ** ADDR;

  // Per-port views of the flattened buses
  logic [NRD-1:0][ADDR-1:0]  ra;
  logic [NWR-1:0][ADDR-1:0]  wa;
  logic [NWR-1:0][TAG-1:0]   wt;
  logic [NWR-1:0][WIDTH-1:0] wd;
  logic [NAL-1:0][ADDR-1:0]  aa;
  logic [NAL-1:0][TAG-1:0]   at;

  assign ra = rd_addr;
  assign wa = wr_addr;
  assign wt = wr_tag;
  assign wd = wr_data;
  assign aa = al_addr;
  assign at = al_tag;

  logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][TAG-1:0]   tag_q, tag_d;

  logic [NWR-1:0] wr_ok_c;
  logic [NAL-1:0] al_ok_c;

  // Address 0 is hardwired: writes and allocations to it are dropped here
  always_comb begin
    wr_ok_c = '0;
    al_ok_c = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      wr_ok_c[j] = wr_en[j] && (wa[j] != '0);
    end
    for (int unsigned k = 0; k < NAL; k++) begin
      al_ok_c[k] = al_en[k] && (aa[k] != '0);
    end
  end

  // Next state: higher-index ports are applied last so they win conflicts
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_ok_c[j]) begin
        regs_d[wa[j]] = wd[j];
        if (wt[j] == tag_q[wa[j]]) begin
          busy_d[wa[j]] = 1'b0;
        end
      end
    end
    // Flush drops same-cycle allocations; otherwise allocation overrides a clear
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned k = 0; k < NAL; k++) begin
        if (al_ok_c[k]) begin
          busy_d[aa[k]] = 1'b1;
          tag_d[aa[k]]  = at[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q                 <= '0;
      regs_q[ADDR'(SP_IDX)]  <= SP_RESET;
      busy_q                 <= '0;
      tag_q                  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  logic [NRD-1:0][WIDTH-1:0] rdata_c;
  logic [NRD-1:0]            rbusy_c;
  logic [NRD-1:0][TAG-1:0]   rtag_c;

  // Combinational source lookup; allocations in flight are never visible
  always_comb begin
`ifdef RF_BYPASS_EN
    logic byp_clr;
    byp_clr = 1'b0;
`endif
    rdata_c = '0;
    rbusy_c = '0;
    rtag_c  = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rdata_c[i] = regs_q[ra[i]];
      rbusy_c[i] = busy_q[ra[i]];
      rtag_c[i]  = tag_q[ra[i]];
`ifdef RF_BYPASS_EN
      byp_clr = 1'b0;
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_ok_c[j] && (wa[j] == ra[i])) begin
          rdata_c[i] = wd[j];
          byp_clr    = (wt[j] == tag_q[ra[i]]);
        end
      end
      if (byp_clr && busy_q[ra[i]]) begin
        rbusy_c[i] = 1'b0;
      end
`endif
      if (ra[i] == '0) begin
        rdata_c[i] = '0;
        rbusy_c[i] = 1'b0;
        rtag_c[i]  = '0;
      end
    end
  end

  assign rd_data = rdata_c;
  assign rd_busy = rbusy_c;
  assign rd_tag  = rtag_c;

endmodule

// File: doc/reg_file_mp_scoreboard.md
Name: reg_file_mp_scoreboard

Overview:
Multi-ported architectural register file for the superscalar core, with an integrated register status table holding a busy bit and a producer tag per register.
- Issue allocates destination registers and records their tags.
- Completion writes data back and clears busy only when the tag still matches.
- Sits between decode/dispatch (source lookup, destination allocation) and the common data bus (writeback).

Parameters:
ADDR, 5, register address width; 2**ADDR registers
WIDTH, 32, data width
NRD, 4, number of read ports
NWR, 2, number of write (writeback) ports
NAL, 2, number of allocation ports
TAG, 6, producer tag width
SP_IDX, 2, index of the stack-pointer register
SP_RESET, 32'h7fffeffc, reset value of register SP_IDX

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low
rd_addr  in  NRD*ADDR  read addresses, port i at [i*ADDR +: ADDR]
rd_data  out  NRD*WIDTH  read data
rd_busy  out  NRD  source not yet available
rd_tag  out  NRD*TAG  producer tag of busy source
wr_en  in  NWR  writeback valid
wr_addr  in  NWR*ADDR  writeback register
wr_tag  in  NWR*TAG  tag of producing instruction
wr_data  in  NWR*WIDTH  writeback data
al_en  in  NAL  allocate destination
al_addr  in  NAL*ADDR  destination register
al_tag  in  NAL*TAG  tag assigned to destination
flush  in  1  synchronous clear of all busy bits (misprediction recovery)

Behaviour:
- Reset is asynchronous, active-low. While rst=0:
  - all registers = 0, except register SP_IDX = SP_RESET;
  - all busy = 0, all tags = 0.
- Reads are combinational; rd_data/rd_busy/rd_tag are purely functions of state and inputs, so they have no reset value of their own.
- Register 0:
  - always reads 0, busy=0, tag=0;
  - writes and allocations to address 0 are ignored.
- Data write: when wr_en[j]=1 and wr_addr[j]!=0, data is stored at the clock edge regardless of tag match, since completion order is resolved upstream.
- Same-cycle write-write conflict on one address: the highest-index write port wins the data.
- Busy clear: busy[r] clears at the edge if some wr_en[j] targets r with wr_tag[j] == stored tag[r].
  - A tag mismatch leaves busy and tag unchanged; a newer producer is still outstanding.
- Allocation: al_en[k] with al_addr[k]!=0 sets busy[r]=1 and tag[r]=al_tag[k] at the edge.
- Same-cycle allocation conflict on one register: the highest-index allocation port wins (latest in program order).
- Allocation vs writeback on the same register in one cycle: allocation wins, so busy stays 1 with the new tag; the data write still happens.
- flush=1:
  - all busy bits clear at the edge; tags hold; data writes in the same cycle still occur;
  - allocations in the same cycle are discarded (flush has priority).
- Read bypass (with RF_BYPASS_EN) for read port i, address r != 0:
  - if a same-cycle write matches r, rd_data = wr_data of the highest-index matching port;
  - if that write's tag equals tag[r] and busy[r]=1, rd_busy = 0.
  - Same-cycle allocations are not visible to reads; dispatch orders lookup before allocate.
- Latency:
  - without bypass, a write is visible to reads 1 cycle after the edge;
  - busy/tag changes are visible 1 cycle after the edge.

Optional Feature:
RF_BYPASS_EN:
- Defined: same-cycle write-to-read forwarding of data and busy as described in Behaviour; read ports see writes in the same cycle.
- Undefined: reads return stored state only. The consumer must wait one cycle after writeback.
- Allocation, busy-clear, flush and reset behaviour are identical in both builds.

Test Plan:
- Reset: drive rst=0 mid-run, then release → x2 reads 32'h7fffeffc; all other registers 0; all rd_busy=0.
- Tag race: al x5 tag 3; next cycle al x5 tag 7; writeback x5 tag 3 data 32'hAAAA → x5 data = 32'hAAAA, busy=1, tag=7. Writeback x5 tag 7 data 32'hBBBB → busy=0, data 32'hBBBB.
- Write conflict: wr port0 x9=32'h1, port1 x9=32'h2 same cycle → x9 reads 32'h2. With RF_BYPASS_EN, the same-cycle read also returns 32'h2.
- Allocation vs writeback: al x4 tag 10 and wr x4 tag 10 data 32'h55 in the same cycle → busy=1, tag=10, data 32'h55.
- Flush with pending allocation: x6, x7 busy; flush=1 with al x8 tag 1 → next cycle x6, x7, x8 all busy=0.
- x0 protection: al x0 and wr x0=32'hFFFF_FFFF → rd x0 returns 0, busy=0. Bypass build: a same-cycle read of x0 returns 0.
